// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding for the skid-buffered pipeline stage
//
// Purpose: state encoding for pipe_stage_skid. The encodings equal the number
// of held beats so the state register doubles as the occupancy output.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// rtl/pipe_stage_skid_sat_counter.sv - saturating event counter
//
// Purpose: counts cycles with inc=1 and sticks at all-ones. Only reset clears it.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high clear
//   inc    in   count this cycle
//   count  out  W-bit saturating count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - generic pipeline stage with 2-entry skid buffer
//
// Purpose: registers a control bundle and a data bundle between pipeline
// stages with valid/ready back-pressure, flush and bubble handling. Control
// is always zero in an empty slot so a bubble never commits side effects.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   flush               empty the stage at the next edge
//   in_valid/in_ready   upstream handshake; in_ctrl/in_data upstream beat
//   out_valid/out_ready downstream handshake; out_ctrl/out_data held beat
//   occupancy           held beats (0..2)
//   stall_cnt           saturating count of out_valid & ~out_ready cycles
//   flush_cnt           saturating count of flush & ~reset cycles
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 128,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid, clr_main, clr_skid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath steering
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clr_main       = 1'b0;
    clr_skid       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      clr_main = 1'b1;
      clr_skid = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d  = ST_EMPTY;
            clr_main = 1'b1;
          end
        end
        ST_TWO: begin
          // Skid beat moves up only when the main beat leaves, preserving order.
          if (out_fire) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
            clr_skid       = 1'b1;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          clr_main = 1'b1;
          clr_skid = 1'b1;
        end
      endcase
    end
  end

  // Handshake outputs depend only on registered state, reset and flush,
  // never on out_ready.
  always_comb begin
    in_ready  = ~reset & ~flush & (state_q != ST_TWO);
    out_valid = (state_q != ST_EMPTY);
    occupancy = state_q;
  end

  // Main and skid registers. Control is cleared whenever a slot empties so
  // out_ctrl is zero on every bubble; data clearing is optional.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl_q <= in_ctrl;
        main_data_q <= in_data;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end else if (clr_main) begin
        main_ctrl_q <= '0;
        if (CLEAR_DATA != 0) begin
          main_data_q <= '0;
        end
      end

      if (load_skid) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
      end else if (clr_skid) begin
        skid_ctrl_q <= '0;
        if (CLEAR_DATA != 0) begin
          skid_data_q <= '0;
        end
      end
    end
  end

  assign out_ctrl = main_ctrl_q;
  assign out_data = main_data_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush & ~reset),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed table-driven bench for pipe_stage_skid
module tb_pipe_stage_skid;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: clearing data, 4-bit counters
  logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0]  in_ctrl, out_ctrl;
  logic [127:0] in_data, out_data;
  logic [1:0]   occupancy;
  logic [3:0]   stall_cnt, flush_cnt;

  // Instance B: data held on bubble
  logic         b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0]  b_in_ctrl, b_out_ctrl;
  logic [127:0] b_in_data, b_out_data;
  logic [1:0]   b_occupancy;
  logic [15:0]  b_stall_cnt, b_flush_cnt;

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(128), .CLEAR_DATA(1), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(128), .CLEAR_DATA(0), .CNT_W(16)) dut_b (
    .clock(clock), .reset(b_reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occupancy), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  typedef struct {
    logic         rst;
    logic         fl;
    logic         iv;
    logic [15:0]  ic;
    logic [127:0] id;
    logic         ordy;
    logic         e_ir;   // in_ready before the edge
    logic         e_ov;   // registered outputs after the edge
    logic [15:0]  e_oc;
    logic [127:0] e_od;
    logic [1:0]   e_occ;
  } vec_t;

  vec_t vecs[18];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clock);
      reset     = vecs[i].rst;
      flush     = vecs[i].fl;
      in_valid  = vecs[i].iv;
      in_ctrl   = vecs[i].ic;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), {127'b0, in_ready}, {127'b0, vecs[i].e_ir});
      @(posedge clock);
      #1;
      check($sformatf("v%0d out_valid", i), {127'b0, out_valid}, {127'b0, vecs[i].e_ov});
      check($sformatf("v%0d out_ctrl", i), {112'b0, out_ctrl}, {112'b0, vecs[i].e_oc});
      check($sformatf("v%0d out_data", i), out_data, vecs[i].e_od);
      check($sformatf("v%0d occupancy", i), {126'b0, occupancy}, {126'b0, vecs[i].e_occ});
    end
  endtask

  initial begin
    //          rst   fl    iv    ic        id           ordy  e_ir  e_ov  e_oc      e_od          e_occ
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 128'h0,      1'b1, 1'b0, 1'b0, 16'h0000, 128'h0,      2'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 128'h0,      1'b1, 1'b0, 1'b0, 16'h0000, 128'h0,      2'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 128'h0,      1'b1, 1'b1, 1'b0, 16'h0000, 128'h0,      2'd0};
    // streaming
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 128'hA,      1'b1, 1'b1, 1'b1, 16'h0001, 128'hA,      2'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 128'hB,      1'b1, 1'b1, 1'b1, 16'h0002, 128'hB,      2'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0003, 128'hC,      1'b1, 1'b1, 1'b1, 16'h0003, 128'hC,      2'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 128'hD,      1'b1, 1'b1, 1'b1, 16'h0004, 128'hD,      2'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 128'h0,      1'b1, 1'b1, 1'b0, 16'h0000, 128'h0,      2'd0};
    // back-pressure
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0011, 128'h111,    1'b0, 1'b1, 1'b1, 16'h0011, 128'h111,    2'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0022, 128'h222,    1'b0, 1'b1, 1'b1, 16'h0011, 128'h111,    2'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0033, 128'h333,    1'b0, 1'b0, 1'b1, 16'h0011, 128'h111,    2'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 128'h0,      1'b0, 1'b0, 1'b1, 16'h0011, 128'h111,    2'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 128'h0,      1'b1, 1'b0, 1'b1, 16'h0022, 128'h222,    2'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 128'h0,      1'b1, 1'b1, 1'b0, 16'h0000, 128'h0,      2'd0};
    // flush while holding two beats, with a beat offered in the flush cycle
    vecs[14] = '{1'b0, 1'b0, 1'b1, 16'h0044, 128'h444,    1'b0, 1'b1, 1'b1, 16'h0044, 128'h444,    2'd1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h0055, 128'h555,    1'b0, 1'b1, 1'b1, 16'h0044, 128'h444,    2'd2};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 16'h0066, 128'h666,    1'b0, 1'b0, 1'b0, 16'h0000, 128'h0,      2'd0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 128'h0,      1'b1, 1'b1, 1'b0, 16'h0000, 128'h0,      2'd0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b1;
    b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 1'b0;

    run_vecs(0, 2);
    check("reset stall_cnt", {124'b0, stall_cnt}, 128'd0);
    check("reset flush_cnt", {124'b0, flush_cnt}, 128'd0);
    run_vecs(3, 7);
    check("stream stall_cnt", {124'b0, stall_cnt}, 128'd0);
    run_vecs(8, 11);
    check("backpressure stall_cnt", {124'b0, stall_cnt}, 128'd3);
    run_vecs(12, 13);
    check("drain stall_cnt", {124'b0, stall_cnt}, 128'd3);
    run_vecs(14, 17);
    check("flush flush_cnt", {124'b0, flush_cnt}, 128'd1);
    check("flush stall_cnt", {124'b0, stall_cnt}, 128'd5);

    // Flush held for three cycles: stays empty, counter steps each cycle
    @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0077; in_data = 128'h777;
    repeat (3) @(posedge clock);
    #1;
    check("held flush occupancy", {126'b0, occupancy}, 128'd0);
    check("held flush out_ctrl", {112'b0, out_ctrl}, 128'd0);
    check("held flush flush_cnt", {124'b0, flush_cnt}, 128'd4);
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;

    // CLEAR_DATA=0 instance: data survives a flush, control does not
    @(negedge clock);
    b_reset = 1'b0; b_in_valid = 1'b1; b_in_ctrl = 16'h0077; b_in_data = 128'hDEAD; b_out_ready = 1'b0;
    @(posedge clock); #1;
    check("B load out_valid", {127'b0, b_out_valid}, 128'd1);
    check("B load out_data", b_out_data, 128'hDEAD);
    @(negedge clock);
    b_in_valid = 1'b0; b_flush = 1'b1;
    #1;
    check("B flush in_ready", {127'b0, b_in_ready}, 128'd0);
    @(posedge clock); #1;
    check("B flush out_valid", {127'b0, b_out_valid}, 128'd0);
    check("B flush out_ctrl", {112'b0, b_out_ctrl}, 128'd0);
    check("B flush out_data", b_out_data, 128'hDEAD);
    check("B flush occupancy", {126'b0, b_occupancy}, 128'd0);
    @(negedge clock);
    b_flush = 1'b0;
    @(posedge clock); #1;
    check("B idle out_data", b_out_data, 128'hDEAD);
    check("B flush_cnt", {112'b0, b_flush_cnt}, 128'd1);

    // Saturation of the 4-bit stall counter
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b1; in_ctrl = 16'h00AB; in_data = 128'hBEEF; out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check("sat stall_cnt", {124'b0, stall_cnt}, 128'd15);
    check("sat out_ctrl stable", {112'b0, out_ctrl}, 128'h00AB);
    repeat (3) @(posedge clock);
    #1;
    check("sat stall_cnt held", {124'b0, stall_cnt}, 128'd15);
    check("sat flush_cnt cleared", {124'b0, flush_cnt}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (ID/EXE style) in the 5-stage CPU.
- One generic stage carries a control bundle and a data bundle. It adds valid/ready back-pressure through a 2-entry skid buffer, plus flush and bubble semantics.
- Control is zeroed on every bubble, so a flushed or empty slot never writes registers or memory.
- Saturating stall and flush counters support pipeline performance debug.

Parameters:
- CTRL_W, 16: width of the control bundle (alu_ctrl, reg_write, mem_write, ...). Zeroed on bubble.
- DATA_W, 128: width of the data bundle (pc, operands, immediate, ...).
- CLEAR_DATA, 1: 1 = data zeroed on bubble/flush/reset; 0 = data holds its last value (saves power).
- CNT_W, 16: width of the stall and flush counters.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill the stage contents at the next edge
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts the beat
- out_ctrl  out  CTRL_W  control to next stage; all zeros whenever out_valid=0
- out_data  out  DATA_W  data to next stage
- occupancy  out  2  number of held beats: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  out  CNT_W  cycles with flush=1 and reset=0, saturating

Behaviour:
- Priority at each edge: reset > flush > normal operation.
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = ~reset & ~flush & (state != ST_TWO). It has no combinational path from out_ready.
- Reset cycle:
  - state = ST_EMPTY; out_valid = 0; out_ctrl = 0; out_data = 0; skid registers = 0; counters = 0.
  - in_ready = 0 while reset is high.
- Main register (out_*) drives the outputs directly. The skid register holds the second beat.
- State transitions:
  - ST_EMPTY: in_fire -> ST_ONE, main <= in. Otherwise stay.
  - ST_ONE: in_fire & out_fire -> ST_ONE, main <= in.
  - ST_ONE: in_fire & ~out_fire -> ST_TWO, skid <= in.
  - ST_ONE: ~in_fire & out_fire -> ST_EMPTY.
  - ST_ONE: neither -> hold.
  - ST_TWO: out_fire -> ST_ONE, main <= skid. Otherwise hold. in_ready = 0 throughout ST_TWO.
- Latency: a beat accepted at edge N is on out_* after edge N (1 cycle). Throughput is 1 beat/cycle with out_ready held high.
- Stall hold: while out_valid=1 and out_ready=0, out_ctrl and out_data are stable and unchanged.
- Order: beats leave in acceptance order; the skid beat is never overtaken.
- Flush (reset=0):
  - State goes to ST_EMPTY; both main and skid are invalidated; out_ctrl = 0.
  - out_data and skid data are zeroed if CLEAR_DATA=1, else held.
  - in_ready = 0 during the flush cycle, so no upstream beat is lost or half-accepted.
  - An out_fire in the flush cycle counts as delivered downstream.
- Flush held multiple cycles: the stage stays empty and flush_cnt increments every such cycle.
- Bubble: whenever out_valid=0, out_ctrl = 0. out_data is 0 if CLEAR_DATA=1.
- occupancy: ST_EMPTY=0, ST_ONE=1, ST_TWO=2. It is registered and consistent with out_valid (out_valid = occupancy != 0).
- Counters: stall_cnt increments on out_valid & ~out_ready; both counters saturate at 2^CNT_W-1 with no wrap. Only reset clears them; flush does not.

Decomposition:
- Package pipe_pkg: state encoding ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2 (equal to the occupancy values).
- Sub-module sat_counter, parameter W, inputs clock/reset/inc, output count. Saturates at all-ones; instantiated twice.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> out_valid=0, out_ctrl=0, out_data=0, in_ready=0 during reset and 1 on the first cycle after, occupancy=0.
- Streaming: out_ready=1, push ctrl 0x0001..0x0004 with data 0xA..0xD on consecutive cycles -> same values on out_* one cycle later each; occupancy stays 1; stall_cnt=0.
- Back-pressure: out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0, out_ctrl=0x11 stable. Then out_ready=1 -> 0x11, 0x22 delivered in order, and stall_cnt equals the number of stalled cycles.
- Flush in ST_TWO: hold 2 beats, pulse flush 1 cycle with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0; no beat accepted that cycle; flush_cnt=1.
- CLEAR_DATA=0 instance: flush after beat data 0xDEAD -> out_ctrl=0, out_valid=0, out_data stays 0xDEAD.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15.
